wb_sequencer: RTL and testbench

- Write-back initiator for the general register file.
- Collects results from three producers and drives the register file's three write channels one registered cycle later:
  - ALU/load pipeline results → general channel
  - multiply/divide unit (MDU) results → special channel, s8 = r30
  - link addresses → ra channel, r31
- Resolves same-cycle conflicts on r30/r31 and buffers MDU results in a small FIFO.
- Exports a busy flag so decode can stall on s8 hazards.

---
 rtl/wb_sequencer_pkg.sv | 16 +
 rtl/wb_fifo.sv | 53 +++++
 rtl/wb_sequencer.sv | 147 ++++++++++++++
 tb/tb_wb_sequencer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sequencer_pkg.sv
// Shared constants and helpers for the write-back sequencer.
// Holds the fixed register indices and the FIFO occupancy-count width function.
package wb_sequencer_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [4:0] ZERO_IDX = 5'd0;
    localparam logic [4:0] S8_IDX   = 5'd30;
    localparam logic [4:0] RA_IDX   = 5'd31;

    // The count must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with registered occupancy count and a combinational head.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import wb_sequencer_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_sequencer.sv
// Write-back initiator: general, s8 (MDU FIFO) and ra (link hold) channels, all registered.
// Optional forwarding lookup is enabled by defining WB_SEQ_FWD_EN.
module wb_sequencer
    import wb_sequencer_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MDU_DEPTH = 4,
    parameter int OUTS_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [4:0]        alu_idx,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              jal_valid,
    input  logic [DATA_W-1:0] jal_data,
    input  logic              mdu_issue,
    // MDU handshake: a result transfers at an edge where mdu_valid and mdu_ready are both 1;
    // mdu_ready depends only on registered occupancy, never on mdu_valid.
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              write,
    output logic [4:0]        RzIndex,
    output logic [DATA_W-1:0] Data_o,
    output logic              Special_En,
    output logic [DATA_W-1:0] Special_o,
    output logic              ra_En,
    output logic [DATA_W-1:0] jal_o,
`ifdef WB_SEQ_FWD_EN
    input  logic [4:0]        fwd_idx,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              s8_busy
);

    localparam int CW = cnt_w(MDU_DEPTH);

    logic              fifo_full, fifo_empty, push, pop;
    logic [CW-1:0]     fifo_count, count_n;
    logic [DATA_W-1:0] fifo_head;
    logic              gen_wr_n, conflict30, conflict31, ra_en_n, busy_n;
    logic [DATA_W-1:0] ra_data_n;
    logic              hold_valid, hold_valid_n;
    logic [DATA_W-1:0] hold_data, hold_data_n;
    logic [OUTS_W-1:0] outs, outs_n;

    assign mdu_ready = !fifo_full;

    wb_fifo #(.W(DATA_W), .DEPTH(MDU_DEPTH)) u_mdu_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (mdu_data),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        gen_wr_n     = alu_valid && (alu_idx != ZERO_IDX);
        conflict30   = alu_valid && (alu_idx == S8_IDX);
        conflict31   = alu_valid && (alu_idx == RA_IDX);
        push         = mdu_valid && mdu_ready;
        pop          = !fifo_empty && !conflict30;
        ra_en_n      = 1'b0;
        ra_data_n    = '0;
        hold_valid_n = hold_valid;
        hold_data_n  = hold_data;
        // A fresh jal is the newer r31 write, so it replaces anything held.
        if (jal_valid) begin
            if (conflict31) begin
                hold_valid_n = 1'b1;
                hold_data_n  = jal_data;
            end else begin
                ra_en_n      = 1'b1;
                ra_data_n    = jal_data;
                hold_valid_n = 1'b0;
            end
        end else if (hold_valid && !conflict31) begin
            ra_en_n      = 1'b1;
            ra_data_n    = hold_data;
            hold_valid_n = 1'b0;
        end
        outs_n = outs;
        if (mdu_issue && !push) begin
            if (outs != '1) outs_n = outs + OUTS_W'(1);
        end else if (push && !mdu_issue) begin
            if (outs != '0) outs_n = outs - OUTS_W'(1);
        end
        count_n = fifo_count + CW'(push) - CW'(pop);
        busy_n  = (count_n != '0) || (outs_n != '0) || pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write      <= 1'b0;
            RzIndex    <= '0;
            Data_o     <= '0;
            Special_En <= 1'b0;
            Special_o  <= '0;
            ra_En      <= 1'b0;
            jal_o      <= '0;
            s8_busy    <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            outs       <= '0;
        end else begin
            write      <= gen_wr_n;
            RzIndex    <= gen_wr_n ? alu_idx : ZERO_IDX;
            Data_o     <= gen_wr_n ? alu_data : '0;
            Special_En <= pop;
            Special_o  <= pop ? fifo_head : '0;
            ra_En      <= ra_en_n;
            jal_o      <= ra_data_n;
            s8_busy    <= busy_n;
            hold_valid <= hold_valid_n;
            hold_data  <= hold_data_n;
            outs       <= outs_n;
        end
    end

`ifdef WB_SEQ_FWD_EN
    // Youngest value for a register wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_idx != ZERO_IDX) begin
            if (hold_valid && fwd_idx == RA_IDX) begin
                fwd_hit = 1'b1; fwd_data = hold_data;
            end else if (write && fwd_idx == RzIndex) begin
                fwd_hit = 1'b1; fwd_data = Data_o;
            end else if (ra_En && fwd_idx == RA_IDX) begin
                fwd_hit = 1'b1; fwd_data = jal_o;
            end else if (!fifo_empty && fwd_idx == S8_IDX) begin
                fwd_hit = 1'b1; fwd_data = fifo_head;
            end else if (Special_En && fwd_idx == S8_IDX) begin
                fwd_hit = 1'b1; fwd_data = Special_o;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: general, MDU FIFO, link hold, busy and reset behaviour.
// Expected results are queued when stimulus is driven and popped when the DUT emits them.
module tb_wb_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, jal_valid, mdu_issue, mdu_valid;
    logic [4:0]  alu_idx;
    logic [31:0] alu_data, jal_data, mdu_data;
    logic        mdu_ready, write, Special_En, ra_En, s8_busy;
    logic [4:0]  RzIndex;
    logic [31:0] Data_o, Special_o, jal_o;
`ifdef WB_SEQ_FWD_EN
    logic [4:0]  fwd_idx = 5'd0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [37:0] gen_q[$];

    always #5 clk = ~clk;

    wb_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_idx    (alu_idx),
        .alu_data   (alu_data),
        .jal_valid  (jal_valid),
        .jal_data   (jal_data),
        .mdu_issue  (mdu_issue),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_data   (mdu_data),
        .write      (write),
        .RzIndex    (RzIndex),
        .Data_o     (Data_o),
        .Special_En (Special_En),
        .Special_o  (Special_o),
        .ra_En      (ra_En),
        .jal_o      (jal_o),
`ifdef WB_SEQ_FWD_EN
        .fwd_idx    (fwd_idx),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
`endif
        .s8_busy    (s8_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_idx = 5'd0; alu_data = 32'd0;
        jal_valid = 1'b0; jal_data = 32'd0;
        mdu_issue = 1'b0; mdu_valid = 1'b0; mdu_data = 32'd0;
    endtask

    task automatic test_reset();
        logic [104:0] obs, want;
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        obs  = {write, RzIndex, Data_o, Special_En, Special_o, ra_En, jal_o, s8_busy};
        want = '0;
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", obs, want);
        end
        total++;
        if (mdu_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", mdu_ready);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_general();
        logic [4:0]  idx_tab [6];
        logic [37:0] got, want;
        logic        wr;
        idx_tab = '{5'd5, 5'd0, 5'd17, 5'd30, 5'd31, 5'd1};
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1'b1;
            alu_idx   = idx_tab[i];
            alu_data  = (i == 0) ? 32'hA5A5_A5A5 : $urandom;
            wr        = (idx_tab[i] != 5'd0);
            gen_q.push_back({wr, wr ? alu_idx : 5'd0, wr ? alu_data : 32'd0});
            step();
            want = gen_q.pop_front();
            got  = {write, RzIndex, Data_o};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL general[%0d] got=%h want=%h", i, got, want);
            end
        end
        idle_inputs();
        step();
        total++;
        if (write !== 1'b0) begin
            bad++;
            $display("FAIL general_idle got=%b want=0", write);
        end
    endtask

    task automatic test_mdu_burst();
        int first_emit = -1;
        exp_q.delete();
        for (int c = 0; c < 10; c++) begin
            if (c < 4) begin
                total++;
                if (mdu_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL burst_ready[%0d] got=%b want=1", c, mdu_ready);
                end
                mdu_valid = 1'b1;
                mdu_data  = 32'(c + 1);
                exp_q.push_back(32'(c + 1));
            end else begin
                mdu_valid = 1'b0;
            end
            step();
            if (Special_En) begin
                if (first_emit < 0) first_emit = c;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL burst_extra got=%h want=none", Special_o);
                end else if (Special_o !== exp_q[0]) begin
                    bad++;
                    $display("FAIL burst_data got=%h want=%h", Special_o, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
        total++;
        if (first_emit != 1) begin
            bad++;
            $display("FAIL burst_latency got=%0d want=1", first_emit);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL burst_drain got=%0d want=0 left", exp_q.size());
        end
    endtask

    task automatic test_fifo_full();
        exp_q.delete();
        alu_valid = 1'b1; alu_idx = 5'd30; alu_data = 32'h5555;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (mdu_ready !== 1'b1) begin
                bad++;
                $display("FAIL full_ready[%0d] got=%b want=1", c, mdu_ready);
            end
            mdu_valid = 1'b1;
            mdu_data  = 32'h21 + 32'(c);
            exp_q.push_back(mdu_data);
            step();
            total++;
            if (Special_En !== 1'b0) begin
                bad++;
                $display("FAIL full_blocked[%0d] got=%b want=0", c, Special_En);
            end
        end
        total++;
        if (mdu_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_not_ready got=%b want=0", mdu_ready);
        end
        mdu_data = 32'h99;
        step();
        total++;
        if (mdu_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_still got=%b want=0", mdu_ready);
        end
        idle_inputs();
        for (int c = 0; c < 8; c++) begin
            step();
            if (Special_En) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL full_extra got=%h want=none", Special_o);
                end else if (Special_o !== exp_q[0]) begin
                    bad++;
                    $display("FAIL full_data got=%h want=%h", Special_o, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL full_drain got=%0d want=0 left", exp_q.size());
        end
    endtask

    task automatic test_r30_conflict();
        exp_q.delete();
        alu_valid = 1'b1; alu_idx = 5'd30; alu_data = 32'h3030;
        mdu_valid = 1'b1; mdu_data = 32'h11;
        exp_q.push_back(32'h11);
        for (int c = 0; c < 3; c++) begin
            step();
            mdu_valid = 1'b0;
            total++;
            if ({Special_En, write, RzIndex} !== {1'b0, 1'b1, 5'd30}) begin
                bad++;
                $display("FAIL r30_hold[%0d] got=%b/%b/%0d want=0/1/30", c, Special_En, write, RzIndex);
            end
        end
        alu_valid = 1'b0;
        step();
        total++;
        if ({Special_En, Special_o} !== {1'b1, exp_q[0]}) begin
            bad++;
            $display("FAIL r30_emit got=%b/%h want=1/%h", Special_En, Special_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
        total++;
        if (RzIndex === 5'd30) begin
            bad++;
            $display("FAIL r30_index got=%0d want=not30", RzIndex);
        end
        step();
    endtask

    task automatic test_jal();
        exp_q.delete();
        for (int rep = 0; rep < 2; rep++) begin
            jal_valid = 1'b1; jal_data = 32'h400;
            alu_valid = 1'b1; alu_idx = 5'd31; alu_data = 32'h7;
            exp_q.push_back(32'h400);
            step();
            total++;
            if ({write, RzIndex, Data_o, ra_En} !== {1'b1, 5'd31, 32'h7, 1'b0}) begin
                bad++;
                $display("FAIL jal_c1[%0d] got=%b/%0d/%h/%b want=1/31/7/0", rep, write, RzIndex, Data_o, ra_En);
            end
            idle_inputs();
            if (rep == 1) begin
                jal_valid = 1'b1; jal_data = 32'h800;
                exp_q.delete();
                exp_q.push_back(32'h800);
            end
            step();
            jal_valid = 1'b0;
            total++;
            if ({ra_En, jal_o} !== {1'b1, exp_q[0]}) begin
                bad++;
                $display("FAIL jal_c2[%0d] got=%b/%h want=1/%h", rep, ra_En, jal_o, exp_q[0]);
            end
            void'(exp_q.pop_front());
            step();
            total++;
            if (ra_En !== 1'b0) begin
                bad++;
                $display("FAIL jal_once[%0d] got=%b want=0", rep, ra_En);
            end
        end
        // Hold survives a second conflict, then drains.
        jal_valid = 1'b1; jal_data = 32'h500;
        alu_valid = 1'b1; alu_idx = 5'd31; alu_data = 32'h1;
        step();
        jal_valid = 1'b0;
        step();
        total++;
        if (ra_En !== 1'b0) begin
            bad++;
            $display("FAIL jal_hold got=%b want=0", ra_En);
        end
        idle_inputs();
        step();
        total++;
        if ({ra_En, jal_o} !== {1'b1, 32'h500}) begin
            bad++;
            $display("FAIL jal_drain got=%b/%h want=1/500", ra_En, jal_o);
        end
    endtask

    task automatic test_all_channels();
        idle_inputs();
        mdu_valid = 1'b1; mdu_data = 32'hC0DE;
        step();
        mdu_valid = 1'b0;
        alu_valid = 1'b1; alu_idx = 5'd5; alu_data = 32'hBEEF;
        jal_valid = 1'b1; jal_data = 32'h123;
        step();
        idle_inputs();
        total++;
        if ({write, RzIndex, Data_o, Special_En, Special_o, ra_En, jal_o} !==
            {1'b1, 5'd5, 32'hBEEF, 1'b1, 32'hC0DE, 1'b1, 32'h123}) begin
            bad++;
            $display("FAIL all_channels got=%b/%0d/%h/%b/%h/%b/%h want=1/5/beef/1/c0de/1/123",
                     write, RzIndex, Data_o, Special_En, Special_o, ra_En, jal_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [37:0] got, want;
        logic        wr;
        idle_inputs();
        for (int i = 0; i < 24; i++) begin
            alu_valid = 1'($urandom_range(0, 1));
            alu_idx   = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            wr        = alu_valid && (alu_idx != 5'd0);
            gen_q.push_back({wr, wr ? alu_idx : 5'd0, wr ? alu_data : 32'd0});
            step();
            want = gen_q.pop_front();
            got  = {write, RzIndex, Data_o};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL b2b[%0d] got=%h want=%h", i, got, want);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_busy_reset();
        logic exp_busy;
        exp_q.delete();
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            mdu_issue = (c < 2);
            if (c == 3 || c == 4) begin
                mdu_valid = 1'b1;
                mdu_data  = 32'h31 + 32'(c - 3);
                exp_q.push_back(mdu_data);
            end
            step();
            exp_busy = (c <= 5);
            total++;
            if (s8_busy !== exp_busy) begin
                bad++;
                $display("FAIL busy[%0d] got=%b want=%b", c, s8_busy, exp_busy);
            end
            if (Special_En) begin
                total++;
                if (exp_q.size() == 0 || Special_o !== exp_q[0]) begin
                    bad++;
                    $display("FAIL busy_data[%0d] got=%h want=%h", c, Special_o,
                             (exp_q.size() == 0) ? 32'd0 : exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        // Load every buffer, then reset before anything drains.
        idle_inputs();
        mdu_issue = 1'b1; mdu_valid = 1'b1; mdu_data = 32'h41;
        alu_valid = 1'b1; alu_idx = 5'd30;
        step();
        mdu_data  = 32'h42;
        alu_idx   = 5'd31;
        jal_valid = 1'b1; jal_data = 32'h777;
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({write, RzIndex, Data_o, Special_En, Special_o, ra_En, jal_o, s8_busy, mdu_ready} !==
            {1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL midreset got=%b/%0d/%h/%b/%h/%b/%h/%b/%b want=all0,ready=1",
                     write, RzIndex, Data_o, Special_En, Special_o, ra_En, jal_o, s8_busy, mdu_ready);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if ({Special_En, ra_En, s8_busy} !== 3'b000) begin
                bad++;
                $display("FAIL discard[%0d] got=%b%b%b want=000", c, Special_En, ra_En, s8_busy);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_general();
        test_mdu_burst();
        test_fifo_full();
        test_r30_conflict();
        test_jal();
        test_all_channels();
        test_back_to_back();
        test_busy_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
